// File: rtl/mem_resp_multicycle_pkg.sv
// Shared definitions for the multicycle data-memory responder.
// State encoding, counter width, default latency and the request-legality rule.
package mem_resp_pkg;

    localparam int unsigned CNT_W       = 4;
    localparam int unsigned DEF_LATENCY = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t RESP = 2'd2;

    // Exactly one of Rd/Wr and a halfword-aligned address.
    function automatic logic req_legal(input logic rd, input logic wr, input logic addr_lsb);
        return (rd ^ wr) & ~addr_lsb;
    endfunction

endpackage

// File: rtl/mem_resp_multicycle_if.sv
// Memory-stage request/response bundle between the pipeline (master) and the
// data-memory responder (slave).
interface mem_resp_multicycle_if;

    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic        createdump;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        err;

    modport master (
        output Addr, DataIn, Rd, Wr, createdump,
        input  DataOut, Done, Stall, CacheHit, err
    );

    modport slave (
        input  Addr, DataIn, Rd, Wr, createdump,
        output DataOut, Done, Stall, CacheHit, err
    );

endinterface

// File: rtl/mem_array16.sv
// Word-organised 16-bit storage: asynchronous read port, synchronous write port.
// Not reset; contents persist across rst.
module mem_array16 #(
    parameter int unsigned AW = 15
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_resp_multicycle.sv
// Multicycle data-memory responder: accepts one access at a time, stalls the
// initiator for LATENCY cycles, then pulses Done with read data or an error.
module mem_resp_multicycle
    import mem_resp_pkg::*;
#(
    parameter int unsigned LATENCY   = DEF_LATENCY,
    parameter int unsigned ADDR_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_resp_multicycle_if.slave  bus
);

    localparam int unsigned AW = ADDR_BITS - 1;
    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [15:0]       dout_q, dout_d;

    logic              req;
    logic              legal;
    logic [AW-1:0]     rd_addr;
    logic [15:0]       rd_data;
    logic              we;

    // The dump hook and any address bits above the array are intentionally ignored.
    logic              unused_inputs;
    assign unused_inputs = ^{bus.createdump, bus.Addr};

    assign req   = bus.Rd | bus.Wr;
    assign legal = req_legal(bus.Rd, bus.Wr, bus.Addr[0]);

    // In IDLE the live address feeds the read port so LATENCY=1 reads resolve on accept.
    assign rd_addr = (state_q == IDLE) ? bus.Addr[ADDR_BITS-1:1] : addr_q;

    // Writes commit on the RESP->IDLE edge; a reset in RESP drops them.
    assign we = (state_q == RESP) && wr_q && !err_q && !rst;

    mem_array16 #(
        .AW(AW)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (addr_q),
        .wdata (wdata_q),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = (!legal || LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        err_d   = err_q;
        dout_d  = dout_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = bus.Addr[ADDR_BITS-1:1];
                    wdata_d = bus.DataIn;
                    wr_d    = bus.Wr;
                    err_d   = !legal;
                    cnt_d   = legal ? CntLoad : '0;
                    dout_d  = (legal && bus.Rd && LATENCY == 1) ? rd_data : '0;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1) && !wr_q) begin
                    dout_d = rd_data;
                end
            end
            RESP: begin
                cnt_d  = '0;
                err_d  = 1'b0;
                dout_d = '0;
            end
            default: begin
                cnt_d  = '0;
                err_d  = 1'b0;
                dout_d = '0;
            end
        endcase
    end

    // Outputs read as reset values while rst is held, so a reset in RESP never shows Done.
    always_comb begin
        bus.Done     = 1'b0;
        bus.Stall    = 1'b0;
        bus.err      = 1'b0;
        bus.DataOut  = '0;
        bus.CacheHit = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: bus.Stall = req;
                BUSY: bus.Stall = 1'b1;
                RESP: begin
                    bus.Done    = 1'b1;
                    bus.err     = err_q;
                    bus.DataOut = dout_q;
                end
                default: bus.Stall = 1'b0;
            endcase
        end
    end

endmodule
